bram_arbiter: RTL

- Shares one `bram` instance (256x16; separate write and read ports; 1-cycle registered read; read-before-write) between two requesters, numbered 0 and 1.
- Arbitration is round-robin, one access granted per cycle.
- The block drives the BRAM control/address/data pins and routes read data back to the requester that issued the read.
- It sits between client engines (e.g. the uFork core and a debug/loader port) and the `bram` instance.

---
 rtl/bram_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/bram_arbiter.sv
// Two-requester round-robin arbiter in front of a 256x16 BRAM (separate write/read ports).
// Latency: grant and BRAM drive are combinational; read data returns 1 cycle after the read grant.
// Backpressure: a requester holds i_reqN until o_gntN; a losing requester waits at most one cycle.
//
// Optional build macro BRAM_ARB_DUAL_EN: when one requester writes and the other reads in
// the same cycle, both are granted together (write port + read port). Undefined: one grant per cycle.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_reqN/i_wrN/i_addrN/i_wdataN requester N access (N = 0, 1)
//   o_gntN                       requester N accepted this cycle (combinational)
//   o_rvalidN/o_rdataN           requester N read return; o_rdataN holds last read value
//   o_wr_en/o_waddr/o_wdata      BRAM write port
//   o_rd_en/o_raddr/i_rdata      BRAM read port
module bram_arbiter #(
  parameter int ADDR_SZ = 8,
  parameter int DATA_SZ = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,

  input  logic               i_req0,
  input  logic               i_wr0,
  input  logic [ADDR_SZ-1:0] i_addr0,
  input  logic [DATA_SZ-1:0] i_wdata0,
  output logic               o_gnt0,
  output logic               o_rvalid0,
  output logic [DATA_SZ-1:0] o_rdata0,

  input  logic               i_req1,
  input  logic               i_wr1,
  input  logic [ADDR_SZ-1:0] i_addr1,
  input  logic [DATA_SZ-1:0] i_wdata1,
  output logic               o_gnt1,
  output logic               o_rvalid1,
  output logic [DATA_SZ-1:0] o_rdata1,

  output logic               o_wr_en,
  output logic [ADDR_SZ-1:0] o_waddr,
  output logic [DATA_SZ-1:0] o_wdata,
  output logic               o_rd_en,
  output logic [ADDR_SZ-1:0] o_raddr,
  input  logic [DATA_SZ-1:0] i_rdata
);

  logic               prio_q, prio_d;
  logic [1:0]         rpend_q, rpend_d;
  logic [DATA_SZ-1:0] hold0_q, hold0_d;
  logic [DATA_SZ-1:0] hold1_q, hold1_d;

  logic               gnt0, gnt1, dual;
  logic               wsel0, wsel1, rsel0, rsel1;

  // Grant selection. Reset suppresses all grants so no access starts while i_rst is high.
  always_comb begin
    dual = 1'b0;
`ifdef BRAM_ARB_DUAL_EN
    // One writer plus one reader can share the cycle: they use different BRAM ports.
    dual = !i_rst && i_req0 && i_req1 && (i_wr0 != i_wr1);
`endif
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!i_rst) begin
      if (dual) begin
        gnt0 = 1'b1;
        gnt1 = 1'b1;
      end else if (i_req0 && (!i_req1 || !prio_q)) begin
        gnt0 = 1'b1;
      end else if (i_req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign wsel0 = gnt0 &  i_wr0;
  assign wsel1 = gnt1 &  i_wr1;
  assign rsel0 = gnt0 & ~i_wr0;
  assign rsel1 = gnt1 & ~i_wr1;

  assign o_gnt0 = gnt0;
  assign o_gnt1 = gnt1;

  // BRAM pins; fields of an unused port are driven to zero.
  always_comb begin
    o_wr_en = wsel0 | wsel1;
    o_waddr = '0;
    o_wdata = '0;
    if (wsel0) begin
      o_waddr = i_addr0;
      o_wdata = i_wdata0;
    end else if (wsel1) begin
      o_waddr = i_addr1;
      o_wdata = i_wdata1;
    end

    o_rd_en = rsel0 | rsel1;
    o_raddr = '0;
    if (rsel0) begin
      o_raddr = i_addr0;
    end else if (rsel1) begin
      o_raddr = i_addr1;
    end
  end

  // Next-state: read tags, hold registers and round-robin pointer.
  always_comb begin
    rpend_d = {rsel1, rsel0};
    hold0_d = rpend_q[0] ? i_rdata : hold0_q;
    hold1_d = rpend_q[1] ? i_rdata : hold1_q;
    prio_d  = prio_q;
    // A dual grant served both sides, so neither gains or loses preference.
    if (!dual) begin
      if (gnt0) begin
        prio_d = 1'b1;
      end else if (gnt1) begin
        prio_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prio_q  <= 1'b0;
      rpend_q <= 2'b00;
      hold0_q <= '0;
      hold1_q <= '0;
    end else begin
      prio_q  <= prio_d;
      rpend_q <= rpend_d;
      hold0_q <= hold0_d;
      hold1_q <= hold1_d;
    end
  end

  // Read return: live BRAM data in the cycle after the read, otherwise the held value.
  // Outputs are forced quiet while reset is asserted.
  assign o_rvalid0 = rpend_q[0] & ~i_rst;
  assign o_rvalid1 = rpend_q[1] & ~i_rst;
  assign o_rdata0  = i_rst ? '0 : (rpend_q[0] ? i_rdata : hold0_q);
  assign o_rdata1  = i_rst ? '0 : (rpend_q[1] ? i_rdata : hold1_q);

endmodule
